// File: rtl/cpu_div_pkg.sv
// Shared definitions for the iterative restoring divider cell.
package cpu_div_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;
    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } div_state_t;

endpackage

// File: rtl/cpu_div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it is non-negative.
module cpu_div_step
    import cpu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // The partial remainder stays below the divisor, so both candidates fit
    // in WIDTH bits; the extra bit only carries the trial sign.
    always_comb begin
        w_shift = {i_rem, i_quo[WIDTH-1]};
        w_trial = w_shift - {1'b0, i_divisor};
        if (!w_trial[WIDTH]) begin
            o_rem = w_trial[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_shift[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/cpu_div_cell.sv
// Iterative signed/unsigned divider with start/busy/done handshake.
// Fixed latency of WIDTH+2 cycles from accepted start to the done pulse.
module cpu_div_cell
    import cpu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             A_div_start,
    input  logic             A_div_signed,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    output logic             A_div_busy,
    output logic             A_div_done,
    output logic [WIDTH-1:0] A_div_quotient,
    output logic [WIDTH-1:0] A_div_remainder,
    output logic             A_div_by_zero
);

    div_state_t       r_state;
    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_src2;
    logic             r_signed;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remout;
    logic             r_bz;

    logic             w_sign1;
    logic             w_sign2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Operand magnitudes and final sign correction; the negation wraps at
    // WIDTH bits, which yields the most-negative / -1 result without a special case.
    always_comb begin
        w_sign1   = r_signed & r_src1[WIDTH-1];
        w_sign2   = r_signed & r_src2[WIDTH-1];
        w_mag1    = w_sign1 ? (-r_src1) : r_src1;
        w_mag2    = w_sign2 ? (-r_src2) : r_src2;
        w_quo_fix = r_neg_q ? (-r_q) : r_q;
        w_rem_fix = r_neg_r ? (-r_rem) : r_rem;
    end

    cpu_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_q),
        .i_divisor (r_div),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    // Control FSM with working registers and registered handshake/results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_src1   <= '0;
            r_src2   <= '0;
            r_signed <= 1'b0;
            r_div    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quot   <= '0;
            r_remout <= '0;
            r_bz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (A_div_start) begin
                        r_src1   <= A_div_src1;
                        r_src2   <= A_div_src2;
                        r_signed <= A_div_signed;
                        r_busy   <= 1'b1;
                        r_state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_div   <= w_mag2;
                    r_q     <= w_mag1;
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_neg_q <= w_sign1 ^ w_sign2;
                    r_neg_r <= w_sign1;
                    r_dz    <= (r_src2 == '0);
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_rem <= w_step_rem;
                    r_q   <= w_step_quo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_quot   <= '1;
                        r_remout <= r_src1;
                        r_bz     <= 1'b1;
                    end else begin
                        r_quot   <= w_quo_fix;
                        r_remout <= w_rem_fix;
                        r_bz     <= 1'b0;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign A_div_busy      = r_busy;
    assign A_div_done      = r_done;
    assign A_div_quotient  = r_quot;
    assign A_div_remainder = r_remout;
    assign A_div_by_zero   = r_bz;

endmodule

// File: tb/tb_cpu_div_cell.sv
// Scoreboard bench for cpu_div_cell: the driver queues expected results,
// a monitor checks them (value and latency) whenever done pulses.
module tb_cpu_div_cell;
    import cpu_div_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        A_div_start = 1'b0;
    logic        A_div_signed = 1'b0;
    logic [31:0] A_div_src1 = '0;
    logic [31:0] A_div_src2 = '0;
    logic        A_div_busy;
    logic        A_div_done;
    logic [31:0] A_div_quotient;
    logic [31:0] A_div_remainder;
    logic        A_div_by_zero;

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [31:0] r;
        logic        bz;
        int unsigned start;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    cpu_div_cell #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .A_div_start     (A_div_start),
        .A_div_signed    (A_div_signed),
        .A_div_src1      (A_div_src1),
        .A_div_src2      (A_div_src2),
        .A_div_busy      (A_div_busy),
        .A_div_done      (A_div_done),
        .A_div_quotient  (A_div_quotient),
        .A_div_remainder (A_div_remainder),
        .A_div_by_zero   (A_div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset_n && A_div_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: actual=done at cycle %0d required=no pending result", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_quotient"}, A_div_quotient, mon_e.q);
                chk({mon_e.name, "_remainder"}, A_div_remainder, mon_e.r);
                chk({mon_e.name, "_by_zero"}, 32'(A_div_by_zero), 32'(mon_e.bz));
                chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.start), 32'(DIV_LATENCY));
                chk({mon_e.name, "_busy_at_done"}, 32'(A_div_busy), 32'd0);
            end
        end
    end

    // Caller must be at a negedge with the DUT in IDLE.
    task automatic start_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [31:0] eq, input logic [31:0] er,
                            input logic ebz);
        exp_t e;
        A_div_src1   = a;
        A_div_src2   = b;
        A_div_signed = s;
        A_div_start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A_div_start = 1'b0;
        e.name  = name;
        e.q     = eq;
        e.r     = er;
        e.bz    = ebz;
        e.start = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int unsigned low = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (A_div_done) begin
                seen = 1'b1;
                break;
            end
            if (!A_div_busy) low++;
            @(negedge clk);
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_busy_low_cycles"}, 32'(low), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input logic ebz);
        start_op(name, a, b, s, eq, er, ebz);
        wait_done(name);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=time limit reached required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(A_div_busy), 32'd0);
        chk("reset_done", 32'(A_div_done), 32'd0);
        chk("reset_quotient", A_div_quotient, 32'd0);
        chk("reset_remainder", A_div_remainder, 32'd0);
        chk("reset_by_zero", 32'(A_div_by_zero), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0);
        run_op("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run_op("s_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0);
        run_op("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0);
        run_op("u_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0);
        run_op("u_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0);
        run_op("s_dz",     32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1);
        run_op("u_dz",     32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1);
        run_op("after_dz", 32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0);

        // Starts while busy and in DONE are ignored; operand changes do nothing.
        start_op("hs", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        A_div_start  = 1'b1;
        A_div_src1   = 32'd5;
        A_div_src2   = 32'd1;
        A_div_signed = 1'b1;
        @(negedge clk);
        A_div_start = 1'b0;
        A_div_src1  = 32'hDEAD_BEEF;
        A_div_src2  = 32'd3;
        repeat (10) @(negedge clk);
        A_div_src1 = 32'd7;
        A_div_src2 = 32'd0;
        wait_done("hs");
        A_div_start  = 1'b1;
        A_div_src1   = 32'd9;
        A_div_src2   = 32'd3;
        A_div_signed = 1'b0;
        @(negedge clk);
        A_div_start = 1'b0;
        repeat (40) @(negedge clk);
        chk("hs_held_quotient", A_div_quotient, 32'd100);
        chk("hs_held_remainder", A_div_remainder, 32'd0);
        chk("hs_idle_busy", 32'(A_div_busy), 32'd0);

        // Back-to-back: start on the IDLE cycle right after done.
        start_op("b2b_a", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0);
        wait_done("b2b_a");
        @(negedge clk);
        run_op("b2b_b", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

        // Asynchronous reset in the middle of the iteration phase.
        start_op("rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        repeat (16) @(negedge clk);
        sb.delete();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(A_div_busy), 32'd0);
        chk("midrst_done", 32'(A_div_done), 32'd0);
        chk("midrst_quotient", A_div_quotient, 32'd0);
        chk("midrst_remainder", A_div_remainder, 32'd0);
        chk("midrst_by_zero", 32'(A_div_by_zero), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
